// File: rtl/valu_elem_sequencer.sv
// Element sequencer for one vector ALU op (vv or vx form) over vl elements.
// Two-stage pipeline: READ captures element operands from the register file,
// EXEC/WB drives the shared scalar ALU and writes the result back through a
// stallable write port.
module valu_elem_sequencer #(
    parameter int unsigned ELEN  = 32,
    parameter int unsigned VLMAX = 8,
    parameter int unsigned IDX_W = $clog2(VLMAX) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       inAluSel,
    input  logic [4:0]       inVd,
    input  logic [4:0]       inVs1,
    input  logic [4:0]       inVs2,
    input  logic [IDX_W-1:0] inVl,
    input  logic             inUseScalar,
    input  logic [ELEN-1:0]  inScalar,
    output logic [4:0]       rdVs1,
    output logic [4:0]       rdVs2,
    output logic [IDX_W-2:0] rdIdx,
    input  logic [ELEN-1:0]  rdData1,
    input  logic [ELEN-1:0]  rdData2,
    output logic [3:0]       aluSel,
    output logic [ELEN-1:0]  aluA,
    output logic [ELEN-1:0]  aluB,
    input  logic [ELEN-1:0]  aluResult,
    output logic             wrEn,
    input  logic             wrReady,
    output logic [4:0]       wrVd,
    output logic [IDX_W-2:0] wrIdx,
    output logic [ELEN-1:0]  wrData,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  vl_q, vl_d;
    logic [4:0]        vd_q, vd_d;
    logic [4:0]        vs1_q, vs1_d;
    logic [4:0]        vs2_q, vs2_d;
    logic              use_scalar_q, use_scalar_d;
    logic [ELEN-1:0]   scalar_q, scalar_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic [IDX_W-2:0]  rd_idx_q, rd_idx_d;
    logic              rd_active_q, rd_active_d;
    logic [IDX_W-2:0]  wr_idx_q, wr_idx_d;
    logic              wr_en_q, wr_en_d;
    logic [ELEN-1:0]   opa_q, opa_d;
    logic [ELEN-1:0]   opb_q, opb_d;

    logic              accept;
    logic              advance;
    logic              last_rd;
    logic              last_wr;
    logic [IDX_W-1:0]  eff_vl;

    // Request handshake, clamped element count and pipeline-advance conditions
    always_comb begin
        eff_vl  = (inVl > IDX_W'(VLMAX)) ? IDX_W'(VLMAX) : inVl;
        accept  = inValid && (state_q == S_IDLE);
        advance = !(wr_en_q && !wrReady);
        last_rd = ({1'b0, rd_idx_q} == (vl_q - IDX_W'(1)));
        last_wr = ({1'b0, wr_idx_q} == (vl_q - IDX_W'(1)));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: RUN ends once the final element's write is accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (eff_vl == '0) ? S_DONE : S_RUN;
            S_RUN:  if (wr_en_q && wrReady && last_wr) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        inReady = (state_q == S_IDLE);
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
    end

    // Datapath next values: latch op on accept, step both stages when not stalled
    always_comb begin
        vl_d         = vl_q;
        vd_d         = vd_q;
        vs1_d        = vs1_q;
        vs2_d        = vs2_q;
        use_scalar_d = use_scalar_q;
        scalar_d     = scalar_q;
        alu_sel_d    = alu_sel_q;
        rd_idx_d     = rd_idx_q;
        rd_active_d  = rd_active_q;
        wr_idx_d     = wr_idx_q;
        wr_en_d      = wr_en_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        if (accept) begin
            vl_d         = eff_vl;
            vd_d         = inVd;
            vs1_d        = inVs1;
            vs2_d        = inVs2;
            use_scalar_d = inUseScalar;
            scalar_d     = inScalar;
            alu_sel_d    = inAluSel;
            rd_idx_d     = '0;
            rd_active_d  = (eff_vl != '0);
            wr_en_d      = 1'b0;
        end else if (state_q == S_RUN && advance) begin
            if (rd_active_q) begin
                opa_d    = rdData1;
                opb_d    = use_scalar_q ? scalar_q : rdData2;
                wr_en_d  = 1'b1;
                wr_idx_d = rd_idx_q;
                // Index parks on the last element rather than wrapping
                if (last_rd) begin
                    rd_active_d = 1'b0;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end else begin
                wr_en_d = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vl_q         <= '0;
            vd_q         <= '0;
            vs1_q        <= '0;
            vs2_q        <= '0;
            use_scalar_q <= 1'b0;
            scalar_q     <= '0;
            alu_sel_q    <= '0;
            rd_idx_q     <= '0;
            rd_active_q  <= 1'b0;
            wr_idx_q     <= '0;
            wr_en_q      <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
        end else begin
            vl_q         <= vl_d;
            vd_q         <= vd_d;
            vs1_q        <= vs1_d;
            vs2_q        <= vs2_d;
            use_scalar_q <= use_scalar_d;
            scalar_q     <= scalar_d;
            alu_sel_q    <= alu_sel_d;
            rd_idx_q     <= rd_idx_d;
            rd_active_q  <= rd_active_d;
            wr_idx_q     <= wr_idx_d;
            wr_en_q      <= wr_en_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
        end
    end

    assign rdVs1  = vs1_q;
    assign rdVs2  = vs2_q;
    assign rdIdx  = rd_idx_q;
    assign aluSel = alu_sel_q;
    assign aluA   = opa_q;
    assign aluB   = opb_q;
    assign wrEn   = wr_en_q;
    assign wrVd   = vd_q;
    assign wrIdx  = wr_idx_q;
    assign wrData = aluResult;

endmodule

// File: tb/tb_valu_elem_sequencer.sv
// Bench for valu_elem_sequencer: register file and ALU models around the DUT,
// an op-level model predicting writes, busy/done/inReady timing, and directed ops.
module tb_valu_elem_sequencer;

    localparam int unsigned ELEN  = 32;
    localparam int unsigned VLMAX = 8;
    localparam int unsigned IDX_W = $clog2(VLMAX) + 1;

    logic             clk;
    logic             rst_n;
    logic             inValid;
    logic             inReady;
    logic [3:0]       inAluSel;
    logic [4:0]       inVd, inVs1, inVs2;
    logic [IDX_W-1:0] inVl;
    logic             inUseScalar;
    logic [ELEN-1:0]  inScalar;
    logic [4:0]       rdVs1, rdVs2;
    logic [IDX_W-2:0] rdIdx;
    logic [ELEN-1:0]  rdData1, rdData2;
    logic [3:0]       aluSel;
    logic [ELEN-1:0]  aluA, aluB, aluResult;
    logic             wrEn;
    logic             wrReady = 1'b1;
    logic [4:0]       wrVd;
    logic [IDX_W-2:0] wrIdx;
    logic [ELEN-1:0]  wrData;
    logic             busy, done;

    valu_elem_sequencer #(.ELEN(ELEN), .VLMAX(VLMAX), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
        .inAluSel(inAluSel), .inVd(inVd), .inVs1(inVs1), .inVs2(inVs2),
        .inVl(inVl), .inUseScalar(inUseScalar), .inScalar(inScalar),
        .rdVs1(rdVs1), .rdVs2(rdVs2), .rdIdx(rdIdx),
        .rdData1(rdData1), .rdData2(rdData2),
        .aluSel(aluSel), .aluA(aluA), .aluB(aluB), .aluResult(aluResult),
        .wrEn(wrEn), .wrReady(wrReady), .wrVd(wrVd), .wrIdx(wrIdx),
        .wrData(wrData), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] s, input logic [31:0] a,
                                          input logic [31:0] b);
        case (s)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return a ^ b;
        endcase
    endfunction

    logic [31:0] rf [32][VLMAX];
    assign rdData1   = rf[rdVs1][rdIdx];
    assign rdData2   = rf[rdVs2][rdIdx];
    assign aluResult = alu_f(aluSel, aluA, aluB);

    always @(posedge clk) begin
        if (rst_n && wrEn && wrReady) rf[wrVd][wrIdx] <= wrData;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  vd;
        int          idx;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  ncnt        = 0;
    int  acc_n       = 0;
    int  acc_cnt     = 0;
    int  op_eff      = 0;
    int  op_stalls   = 0;
    bit  op_live     = 1'b0;
    bit  model_ready = 1'b1;
    int  wr_cnt      = 0;
    int  stall_idx   = -1;
    int  stall_left  = 0;

    // Op model: on acceptance, predict every element write from a register-file snapshot
    always @(posedge clk) begin
        if (rst_n && inValid && model_ready) begin
            int eff;
            eff = (int'(inVl) > int'(VLMAX)) ? int'(VLMAX) : int'(inVl);
            for (int k = 0; k < eff; k++) begin
                wr_t w;
                logic [31:0] a, b;
                a      = rf[inVs1][k];
                b      = inUseScalar ? inScalar : rf[inVs2][k];
                w.vd   = inVd;
                w.idx  = k;
                w.data = alu_f(inAluSel, a, b);
                exp_q.push_back(w);
            end
            op_live     = 1'b1;
            op_eff      = eff;
            op_stalls   = 0;
            acc_n       = ncnt;
            acc_cnt++;
            model_ready = 1'b0;
        end
    end

    // Per-cycle compare against the model; also drives write back-pressure
    always @(negedge clk) begin
        ncnt++;
        if (!rst_n) begin
            exp_q.delete();
            op_live     = 1'b0;
            model_ready = 1'b1;
            wrReady     = 1'b1;
        end else begin
            int  rel, done_rel;
            bit  exp_busy, exp_done, exp_wr;
            if (stall_left > 0 && wrEn && int'(wrIdx) == stall_idx) begin
                wrReady = 1'b0;
                stall_left--;
            end else begin
                wrReady = 1'b1;
            end
            rel      = ncnt - acc_n;
            done_rel = (op_eff == 0) ? 1 : op_eff + 2 + op_stalls;
            exp_busy = op_live && op_eff != 0 && rel < done_rel;
            exp_done = op_live && rel == done_rel;
            exp_wr   = op_live && op_eff != 0 && rel >= 2 && rel < done_rel;
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("inReady", 32'(inReady), 32'(!op_live));
            chk("wrEn", 32'(wrEn), 32'(exp_wr));
            if (wrEn) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(wrEn), 32'd0);
                end else begin
                    chk("wrVd", 32'(wrVd), 32'(exp_q[0].vd));
                    chk("wrIdx", 32'(wrIdx), 32'(exp_q[0].idx));
                    chk("wrData", wrData, exp_q[0].data);
                    if (wrReady) begin
                        void'(exp_q.pop_front());
                        wr_cnt++;
                    end else begin
                        op_stalls++;
                    end
                end
            end
            if (busy) chk("rdIdx_bound", 32'(int'(rdIdx) < op_eff), 32'd1);
            model_ready = !op_live;
            if (exp_done) op_live = 1'b0;
        end
    end

    task automatic issue(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [IDX_W-1:0] vl, input logic us, input logic [31:0] sc,
                         input logic [3:0] sel, input int st_idx, input int st_len);
        int c0;
        @(negedge clk);
        inVd = vd; inVs1 = vs1; inVs2 = vs2; inVl = vl;
        inUseScalar = us; inScalar = sc; inAluSel = sel;
        stall_idx = st_idx; stall_left = st_len;
        c0 = acc_cnt;
        inValid = 1'b1;
        for (int i = 0; i < 50 && acc_cnt == c0; i++) @(negedge clk);
        chk("accept", 32'(acc_cnt - c0), 32'd1);
        inValid = 1'b0;
    endtask

    // Called at the first negedge after acceptance; returns done's cycle offset from T
    task automatic wait_done(output int r);
        r = 1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            r++;
        end
        chk("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int r, w0, a1, c0;
        rst_n = 1'b0; inValid = 1'b0; inAluSel = '0; inVd = '0; inVs1 = '0; inVs2 = '0;
        inVl = '0; inUseScalar = 1'b0; inScalar = '0;
        for (int i = 0; i < 32; i++)
            for (int k = 0; k < int'(VLMAX); k++) rf[i][k] = 32'd0;
        for (int k = 0; k < int'(VLMAX); k++) begin
            rf[1][k] = 32'(k + 1);
            rf[2][k] = 32'(10 * (k + 1));
            rf[9][k] = 32'd999;
        end
        rf[5][0] = 32'd5; rf[5][1] = 32'd6; rf[5][2] = 32'd7;
        #1;
        chk("rst_wrEn", 32'(wrEn), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_inReady", 32'(inReady), 32'd1);
        chk("rst_rdIdx", 32'(rdIdx), 32'd0);
        chk("rst_wrIdx", 32'(wrIdx), 32'd0);
        chk("rst_aluSel", 32'(aluSel), 32'd0);
        chk("rst_aluA", aluA, 32'd0);
        chk("rst_aluB", aluB, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // vv add, vl=4
        w0 = wr_cnt;
        issue(5'd3, 5'd1, 5'd2, 4'd4, 1'b0, 32'd0, 4'b0010, -1, 0);
        wait_done(r);
        chk("vv_done_rel", 32'(r), 32'd6);
        chk("vv_writes", 32'(wr_cnt - w0), 32'd4);
        chk("vv_e0", rf[3][0], 32'd11);
        chk("vv_e1", rf[3][1], 32'd22);
        chk("vv_e2", rf[3][2], 32'd33);
        chk("vv_e3", rf[3][3], 32'd44);

        // vx sub, vl=3, vs2 holds junk that must not be used
        w0 = wr_cnt;
        issue(5'd4, 5'd5, 5'd9, 4'd3, 1'b1, 32'd2, 4'b0110, -1, 0);
        wait_done(r);
        chk("vx_done_rel", 32'(r), 32'd5);
        chk("vx_writes", 32'(wr_cnt - w0), 32'd3);
        chk("vx_e0", rf[4][0], 32'd3);
        chk("vx_e1", rf[4][1], 32'd4);
        chk("vx_e2", rf[4][2], 32'd5);

        // two-cycle stall on element 1
        w0 = wr_cnt;
        issue(5'd6, 5'd1, 5'd2, 4'd4, 1'b0, 32'd0, 4'b0010, 1, 2);
        wait_done(r);
        chk("stall_done_rel", 32'(r), 32'd8);
        chk("stall_writes", 32'(wr_cnt - w0), 32'd4);
        chk("stall_e1", rf[6][1], 32'd22);
        chk("stall_e3", rf[6][3], 32'd44);

        // vl=0
        w0 = wr_cnt;
        issue(5'd11, 5'd1, 5'd2, 4'd0, 1'b0, 32'd0, 4'b0010, -1, 0);
        wait_done(r);
        chk("vl0_done_rel", 32'(r), 32'd1);
        chk("vl0_writes", 32'(wr_cnt - w0), 32'd0);

        // vl=12 clamps to VLMAX
        w0 = wr_cnt;
        issue(5'd7, 5'd1, 5'd2, 4'd12, 1'b0, 32'd0, 4'b0010, -1, 0);
        wait_done(r);
        chk("vlmax_done_rel", 32'(r), 32'd10);
        chk("vlmax_writes", 32'(wr_cnt - w0), 32'd8);
        chk("vlmax_e7", rf[7][7], 32'd88);

        // destination overlaps source 1
        issue(5'd1, 5'd1, 5'd2, 4'd8, 1'b0, 32'd0, 4'b0010, -1, 0);
        wait_done(r);
        chk("ovl_done_rel", 32'(r), 32'd10);
        chk("ovl_e0", rf[1][0], 32'd11);
        chk("ovl_e7", rf[1][7], 32'd88);

        // inValid held through an op: the second accept waits for IDLE
        w0 = wr_cnt;
        @(negedge clk);
        inVd = 5'd8; inVs1 = 5'd2; inVs2 = 5'd2; inVl = 4'd2;
        inUseScalar = 1'b0; inScalar = '0; inAluSel = 4'b0010;
        c0 = acc_cnt;
        inValid = 1'b1;
        for (int i = 0; i < 50 && acc_cnt == c0; i++) @(negedge clk);
        a1 = acc_n;
        for (int i = 0; i < 50 && acc_cnt < c0 + 2; i++) @(negedge clk);
        inValid = 1'b0;
        chk("held_accepts", 32'(acc_cnt - c0), 32'd2);
        chk("reaccept_gap", 32'(acc_n - a1), 32'd5);
        wait_done(r);
        chk("held_done_rel", 32'(r), 32'd4);
        chk("held_writes", 32'(wr_cnt - w0), 32'd4);
        chk("held_e1", rf[8][1], 32'd40);

        // asynchronous reset after element 1 is written
        issue(5'd10, 5'd2, 5'd2, 4'd4, 1'b0, 32'd0, 4'b0010, -1, 0);
        for (int i = 0; i < 20 && !(wrEn && wrIdx == 3'd1); i++) @(negedge clk);
        chk("rst_mid_reached", 32'(wrEn && wrIdx == 3'd1), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_wrEn", 32'(wrEn), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_inReady", 32'(inReady), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("rstmid_e1", rf[10][1], 32'd40);
        chk("rstmid_e2", rf[10][2], 32'd0);
        chk("rstmid_e3", rf[10][3], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
